// File: rtl/direction_pkg.sv
// Shared definitions for the beam-break direction decoder: FSM state
// encoding and the debounced {a,b} sensor patterns the FSM reacts to.
package direction_pkg;

  localparam int STATE_W = 3;

  // Traversal states; A* follow an entry (outer sensor first), B* an exit.
  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    A1         = 3'd1,
    A2         = 3'd2,
    A3         = 3'd3,
    B1         = 3'd4,
    B2         = 3'd5,
    B3         = 3'd6,
    WAIT_CLEAR = 3'd7
  } dir_state_t;

  // Debounced sensor pair, packed as {a, b}.
  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_B    = 2'b01;
  localparam logic [1:0] PAT_A    = 2'b10;
  localparam logic [1:0] PAT_AB   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: two-flop synchronizer followed by a counter that
// only lets the level change after DEB_CYCLES consecutive differing samples.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic MR_N,
  input  logic RAW,
  output logic LEVEL
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          syncStage1;
  logic          syncStage2;
  logic [CW-1:0] debCount;

  // Bring the asynchronous beam-break line into the CLK domain.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      syncStage1 <= 1'b0;
      syncStage2 <= 1'b0;
    end else begin
      syncStage1 <= RAW;
      syncStage2 <= syncStage1;
    end
  end

  // Flip the level on the DEB_CYCLES-th consecutive differing sample; any agreement restarts the count.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      debCount <= '0;
      LEVEL    <= 1'b0;
    end else if (syncStage2 == LEVEL) begin
      debCount <= '0;
    end else if (debCount == CW'(DEB_CYCLES - 1)) begin
      debCount <= '0;
      LEVEL    <= syncStage2;
    end else begin
      debCount <= debCount + 1'b1;
    end
  end

endmodule

// File: rtl/direction_decoder.sv
// Converts the two beam-break sensors into one-cycle UP/DOWN count
// commands, flagging aborted, illegal or stalled traversals with ERR.
module direction_decoder
  import direction_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic CLK,
  input  logic MR_N,
  input  logic SA,
  input  logic SB,
  output logic UP,
  output logic DOWN,
  output logic ERR,
  output logic BUSY
);

  localparam int DW = $clog2(TIMEOUT + 1);

  logic          levelA;
  logic          levelB;
  logic [1:0]    pattern;
  dir_state_t    state;
  dir_state_t    stateNext;
  logic [DW-1:0] dwell;
  logic          stalled;
  logic          upNext;
  logic          downNext;
  logic          errNext;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) debA (
    .CLK   (CLK),
    .MR_N  (MR_N),
    .RAW   (SA),
    .LEVEL (levelA)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) debB (
    .CLK   (CLK),
    .MR_N  (MR_N),
    .RAW   (SB),
    .LEVEL (levelB)
  );

  assign pattern = {levelA, levelB};
  assign stalled = (dwell >= DW'(TIMEOUT - 1));

  // Next-state decode: legal steps and backtracks, otherwise ERR; timeout only when the state would hold.
  always_comb begin
    stateNext = state;
    upNext    = 1'b0;
    downNext  = 1'b0;
    errNext   = 1'b0;
    case (state)
      IDLE: begin
        case (pattern)
          PAT_A:   stateNext = A1;
          PAT_B:   stateNext = B1;
          PAT_AB:  begin errNext = 1'b1; stateNext = WAIT_CLEAR; end
          default: stateNext = IDLE;
        endcase
      end
      A1: begin
        case (pattern)
          PAT_AB:   stateNext = A2;
          PAT_NONE: stateNext = IDLE;
          PAT_B:    begin errNext = 1'b1; stateNext = WAIT_CLEAR; end
          default:  stateNext = A1;
        endcase
      end
      A2: begin
        case (pattern)
          PAT_B:    stateNext = A3;
          PAT_A:    stateNext = A1;
          PAT_NONE: begin errNext = 1'b1; stateNext = WAIT_CLEAR; end
          default:  stateNext = A2;
        endcase
      end
      A3: begin
        case (pattern)
          PAT_NONE: begin downNext = 1'b1; stateNext = IDLE; end
          PAT_AB:   stateNext = A2;
          PAT_A:    begin errNext = 1'b1; stateNext = WAIT_CLEAR; end
          default:  stateNext = A3;
        endcase
      end
      B1: begin
        case (pattern)
          PAT_AB:   stateNext = B2;
          PAT_NONE: stateNext = IDLE;
          PAT_A:    begin errNext = 1'b1; stateNext = WAIT_CLEAR; end
          default:  stateNext = B1;
        endcase
      end
      B2: begin
        case (pattern)
          PAT_A:    stateNext = B3;
          PAT_B:    stateNext = B1;
          PAT_NONE: begin errNext = 1'b1; stateNext = WAIT_CLEAR; end
          default:  stateNext = B2;
        endcase
      end
      B3: begin
        case (pattern)
          PAT_NONE: begin upNext = 1'b1; stateNext = IDLE; end
          PAT_AB:   stateNext = B2;
          PAT_B:    begin errNext = 1'b1; stateNext = WAIT_CLEAR; end
          default:  stateNext = B3;
        endcase
      end
      default: begin
        if (pattern == PAT_NONE) stateNext = IDLE;
      end
    endcase
    if (stateNext == state && state != IDLE && state != WAIT_CLEAR && stalled) begin
      errNext   = 1'b1;
      stateNext = WAIT_CLEAR;
    end
  end

  // State, dwell counter and registered outputs advance together on each clock.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      state <= IDLE;
      dwell <= '0;
      UP    <= 1'b0;
      DOWN  <= 1'b0;
      ERR   <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      state <= stateNext;
      UP    <= upNext;
      DOWN  <= downNext;
      ERR   <= errNext;
      BUSY  <= (stateNext != IDLE);
      if (stateNext != state || state == IDLE || state == WAIT_CLEAR) begin
        dwell <= '0;
      end else if (dwell != DW'(TIMEOUT)) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_direction_decoder.sv
// Directed bench for direction_decoder with DEB_CYCLES=4, TIMEOUT=50.
// Raw inputs change on the falling edge; outputs are read on the falling edge.
module tb_direction_decoder;

  logic CLK;
  logic mrN;
  logic sa;
  logic sb;
  logic up;
  logic down;
  logic err;
  logic busy;

  int checks = 0;
  int errors = 0;

  int upCnt     = 0;
  int downCnt   = 0;
  int errCnt    = 0;
  int busyCnt   = 0;
  int multiHigh = 0;

  int up0;
  int down0;
  int err0;
  int busy0;

  direction_decoder #(
    .DEB_CYCLES (4),
    .TIMEOUT    (50)
  ) dut (
    .CLK  (CLK),
    .MR_N (mrN),
    .SA   (sa),
    .SB   (sb),
    .UP   (up),
    .DOWN (down),
    .ERR  (err),
    .BUSY (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Tally how many cycles each output was high, plus any cycle where pulses overlap.
  always @(posedge CLK) begin
    upCnt   = upCnt + int'(up);
    downCnt = downCnt + int'(down);
    errCnt  = errCnt + int'(err);
    busyCnt = busyCnt + int'(busy);
    if ((int'(up) + int'(down) + int'(err)) > 1) multiHigh = multiHigh + 1;
  end

  // Drive both raw sensors and hold them for n clock cycles.
  task automatic applyStimulus(input logic a, input logic b, input int n);
    sa = a;
    sb = b;
    repeat (n) @(negedge CLK);
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Remember the running pulse tallies so each scenario can check its own deltas.
  task automatic snapshot();
    up0   = upCnt;
    down0 = downCnt;
    err0  = errCnt;
    busy0 = busyCnt;
  endtask

  // Directed scenario sequence.
  initial begin
    mrN = 1'b0;
    sa  = 1'b1;
    sb  = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("reset_up", up, 1'b0);
    checkOutput("reset_down", down, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);

    $display("[TB] release reset with both beams broken");
    snapshot();
    mrN = 1'b1;
    applyStimulus(1'b1, 1'b1, 12);
    checkOutput("idle11_err_count", errCnt - err0, 1);
    checkOutput("idle11_busy_waitclear", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("idle11_busy_cleared", busy, 1'b0);
    checkOutput("idle11_no_up", upCnt - up0, 0);
    checkOutput("idle11_no_down", downCnt - down0, 0);

    $display("[TB] entry traversal A then B");
    snapshot();
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("entry_busy_a1", busy, 1'b1);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("entry_down_early", down, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("entry_down_at7", down, 1'b1);
    checkOutput("entry_busy_low_at7", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("entry_down_width", down, 1'b0);
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("entry_down_count", downCnt - down0, 1);
    checkOutput("entry_no_up", upCnt - up0, 0);
    checkOutput("entry_no_err", errCnt - err0, 0);

    $display("[TB] exit traversal B then A");
    snapshot();
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("exit_up_count", upCnt - up0, 1);
    checkOutput("exit_no_down", downCnt - down0, 0);
    checkOutput("exit_no_err", errCnt - err0, 0);

    $display("[TB] backtrack A1 A2 A1 IDLE");
    snapshot();
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("back_busy_a2", busy, 1'b1);
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("back_pulses", (upCnt - up0) + (downCnt - down0) + (errCnt - err0), 0);
    checkOutput("back_busy_idle", busy, 1'b0);

    $display("[TB] glitches on sensor A");
    snapshot();
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("glitch3_busy_cycles", busyCnt - busy0, 0);
    snapshot();
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("glitch5_busy_cycles", busyCnt - busy0, 5);
    checkOutput("glitch5_pulses", (upCnt - up0) + (downCnt - down0) + (errCnt - err0), 0);
    checkOutput("glitch5_busy_idle", busy, 1'b0);

    $display("[TB] stalled traversal times out");
    snapshot();
    applyStimulus(1'b1, 1'b0, 7);
    checkOutput("timeout_a1_entry", busy, 1'b1);
    applyStimulus(1'b1, 1'b0, 49);
    checkOutput("timeout_err_early", err, 1'b0);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("timeout_err_at50", err, 1'b1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("timeout_err_width", err, 1'b0);
    applyStimulus(1'b1, 1'b0, 42);
    checkOutput("timeout_busy_waitclear", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("timeout_busy_before_clear", busy, 1'b1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("timeout_busy_cleared", busy, 1'b0);
    checkOutput("timeout_err_count", errCnt - err0, 1);
    checkOutput("timeout_no_count", (upCnt - up0) + (downCnt - down0), 0);

    $display("[TB] illegal A then B without overlap");
    snapshot();
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 20);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("illegal_err_count", errCnt - err0, 1);
    checkOutput("illegal_no_down", downCnt - down0, 0);
    checkOutput("illegal_busy_idle", busy, 1'b0);

    $display("[TB] reset during A3");
    snapshot();
    applyStimulus(1'b1, 1'b0, 20);
    applyStimulus(1'b1, 1'b1, 20);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("midreset_busy_a3", busy, 1'b1);
    mrN = 1'b0;
    #1;
    checkOutput("midreset_busy_async", busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 2);
    mrN = 1'b1;
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("midreset_no_down", downCnt - down0, 0);
    checkOutput("midreset_no_err", errCnt - err0, 0);
    checkOutput("midreset_busy_idle", busy, 1'b0);

    checkOutput("pulse_exclusive", multiHigh, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
